// File: rtl/ap_eval_pkg.sv
// ap_eval_pkg: shared state encoding and default operand width for the
// approximate-multiplier error evaluator.
`default_nettype none

package ap_eval_pkg;

  localparam int AP_EVAL_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ap_eval_acc.sv
// ap_eval_acc: stage-2 error-distance and metric accumulation.
// Optional signed bias accumulator enabled by macro AP_EVAL_BIAS_EN.
`default_nettype none

module ap_eval_acc
  import ap_eval_pkg::*;
#(
  parameter int W = AP_EVAL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             valid,
  input  logic [2*W-1:0]   ap,
  input  logic [2*W-1:0]   exact,
  output logic [2*W:0]     err_cnt,
  output logic [4*W-1:0]   sum_ed,
  output logic [2*W-1:0]   max_ed
`ifdef AP_EVAL_BIAS_EN
  ,output logic signed [4*W:0] bias_sum
`endif
);

  logic [2*W-1:0] ed;

  always_comb begin
    ed = (ap >= exact) ? (ap - exact) : (exact - ap);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if (valid) begin
      if (ed != '0) err_cnt <= err_cnt + {{(2*W){1'b0}}, 1'b1};
      sum_ed <= sum_ed + {{(2*W){1'b0}}, ed};
      if (ed > max_ed) max_ed <= ed;
    end
  end

`ifdef AP_EVAL_BIAS_EN
  // Widened by one bit so the unsigned operands difference is exact.
  logic signed [2*W:0] diff;

  always_comb begin
    diff = $signed({1'b0, ap}) - $signed({1'b0, exact});
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      bias_sum <= '0;
    end else if (valid) begin
      bias_sum <= bias_sum + {{(2*W){diff[2*W]}}, diff};
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/ap_mult_err_eval.sv
// ap_mult_err_eval: exhaustive operand sweep and error metrics for an external
// approximate multiplier. Macro AP_EVAL_BIAS_EN adds the signed bias_sum output.
`default_nettype none

module ap_mult_err_eval
  import ap_eval_pkg::*;
#(
  parameter int W = AP_EVAL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [2*W-1:0]   ap_res,
  output logic             busy,
  output logic             done,
  output logic [2*W:0]     err_cnt,
  output logic [4*W-1:0]   sum_ed,
  output logic [2*W-1:0]   max_ed
`ifdef AP_EVAL_BIAS_EN
  ,output logic signed [4*W:0] bias_sum
`endif
);

  state_t         state;
  logic [2*W-1:0] cnt;
  logic [2*W-1:0] exact;
  logic [2*W-1:0] s1_ap;
  logic [2*W-1:0] s1_ex;
  logic           s1_v;
  logic           start_ok;

  assign op_a = cnt[2*W-1:W];
  assign op_b = cnt[W-1:0];

  always_comb begin
    exact    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    start_ok = start && ((state == IDLE) || (state == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s1_ap <= '0;
      s1_ex <= '0;
      s1_v  <= 1'b0;
    end else begin
      s1_ap <= ap_res;
      s1_ex <= exact;
      s1_v  <= (state == RUN);
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        RUN: begin
          // Counter parks at all-ones so op_a/op_b stay on the last pair.
          if (cnt == '1) state <= DRAIN;
          else           cnt   <= cnt + {{(2*W-1){1'b0}}, 1'b1};
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ap_eval_acc #(.W(W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .valid   (s1_v),
    .ap      (s1_ap),
    .exact   (s1_ex),
    .err_cnt (err_cnt),
    .sum_ed  (sum_ed),
    .max_ed  (max_ed)
`ifdef AP_EVAL_BIAS_EN
    ,.bias_sum(bias_sum)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_ap_mult_err_eval.sv
// tb_ap_mult_err_eval: scoreboard bench with a stub multiplier and a
// behavioural reference model of the sweep metrics.
`default_nettype none

module tb_ap_mult_err_eval;

  localparam int W     = 4;
  localparam int N     = 1 << (2 * W);
  localparam int SWEEP = N + 1;

  typedef struct {
    longint err;
    longint sum;
    longint mx;
    longint bias;
    longint start_edge;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] ap_res;
  logic [2*W-1:0] prod;
  logic           busy, done;
  logic [2*W:0]   err_cnt;
  logic [4*W-1:0] sum_ed;
  logic [2*W-1:0] max_ed;
`ifdef AP_EVAL_BIAS_EN
  logic signed [4*W:0] bias_sum;
`endif

  exp_t   sb[$];
  exp_t   mon_e;
  int     checks = 0;
  int     failures = 0;
  longint cyc = 0;
  int     busy_cnt = 0;
  bit     done_q = 1'b0;
  int     mode = 0;
  logic [2*W-1:0] lut [N];

  ap_mult_err_eval #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .ap_res  (ap_res),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .sum_ed  (sum_ed),
    .max_ed  (max_ed)
`ifdef AP_EVAL_BIAS_EN
    ,.bias_sum(bias_sum)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub multiplier: 0 exact, 1 bit0 forced low, 2 zero, 3 random table.
  always_comb begin
    prod = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    case (mode)
      0:       ap_res = prod;
      1:       ap_res = {prod[2*W-1:1], 1'b0};
      2:       ap_res = '0;
      default: ap_res = lut[{op_a, op_b}];
    endcase
  end

  task automatic chk(input string nm, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic exp_t model(input int m);
    exp_t e;
    e = '{0, 0, 0, 0, 0};
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        longint ex, ap, d;
        ex = a * b;
        case (m)
          0:       ap = ex;
          1:       ap = ex - (ex % 2);
          2:       ap = 0;
          default: ap = longint'(lut[a * (1 << W) + b]);
        endcase
        d = ap - ex;
        e.bias += d;
        if (d < 0) d = -d;
        if (d != 0) e.err++;
        e.sum += d;
        if (d > e.mx) e.mx = d;
      end
    end
    return e;
  endfunction

  // Monitor: compares final metrics and timing whenever done rises.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      done_q   = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("err_cnt", longint'(err_cnt), mon_e.err);
          chk("sum_ed", longint'(sum_ed), mon_e.sum);
          chk("max_ed", longint'(max_ed), mon_e.mx);
`ifdef AP_EVAL_BIAS_EN
          chk("bias_sum", longint'(bias_sum), mon_e.bias);
`endif
          chk("done_latency", cyc, mon_e.start_edge + SWEEP);
          chk("busy_cycles", busy_cnt, SWEEP);
        end
        busy_cnt = 0;
      end
      done_q = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_op_a"}, longint'(op_a), 0);
    chk({tag, "_op_b"}, longint'(op_b), 0);
    chk({tag, "_err_cnt"}, longint'(err_cnt), 0);
    chk({tag, "_sum_ed"}, longint'(sum_ed), 0);
    chk({tag, "_max_ed"}, longint'(max_ed), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
`ifdef AP_EVAL_BIAS_EN
    chk({tag, "_bias_sum"}, longint'(bias_sum), 0);
`endif
  endtask

  task automatic run_sweep(input int m, input bit glitch);
    exp_t e;
    int   n;
    mode = m;
    e = model(m);
    step();
    start = 1'b1;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    step();
    start = 1'b0;
    chk("start_busy", longint'(busy), 1);
    chk("start_done_clr", longint'(done), 0);
    chk("start_err_clr", longint'(err_cnt), 0);
    n = 0;
    while (!done && n < 2 * SWEEP) begin
      start = glitch && ($urandom_range(0, 7) == 0);
      step();
      n++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", longint'(done), 1);
      sb.delete();
    end else begin
      chk("op_a_last", longint'(op_a), (1 << W) - 1);
      chk("op_b_last", longint'(op_b), (1 << W) - 1);
      repeat (3) step();
      chk("hold_done", longint'(done), 1);
      chk("hold_sum_ed", longint'(sum_ed), e.sum);
      chk("hold_op_a", longint'(op_a), (1 << W) - 1);
    end
  endtask

  task automatic fill_lut();
    for (int i = 0; i < N; i++) begin
      logic [2*W-1:0] ex;
      ex = 8'((i >> W) * (i % (1 << W)));
      if ($urandom_range(0, 3) == 0) lut[i] = 8'($urandom);
      else                           lut[i] = ex;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) step();
    check_zero("reset");
    rst = 1'b0;

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b1);
    run_sweep(2, 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_lut();
      run_sweep(3, 1'b1);
    end

    // Abort 100 cycles into RUN, then a clean sweep.
    mode = 1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (99) step();
    rst = 1'b1;
    step();
    check_zero("abort");
    rst = 1'b0;
    sb.delete();
    run_sweep(1, 1'b0);

    // rst and start at the same edge.
    step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    check_zero("rst_start");
    step();
    chk("rst_start_idle_busy", longint'(busy), 0);
    sb.delete();

    fill_lut();
    run_sweep(3, 1'b1);

    repeat (3) step();
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
